// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Optional feature macro used by the fetch files: FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 3;

  localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Clears the byte-offset bits so the PC always names a whole word.
  function automatic logic [WORD_W-1:0] alignWord(input logic [WORD_W-1:0] addr);
    return addr & ~(PC_STEP - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable 3-bit down-counter that paces instruction-memory settle time.
// Stops at zero and reports it through o_zero.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= RESET_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register and WAIT/HOLD(/HALT) control.
// Define FETCH_ALIGN_CHECK_EN to halt on misaligned redirects instead of masking them.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                MEM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] ir_pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              misalign_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_ir_pc;
  logic [WORD_W-1:0] r_pc_plus4;

  logic w_cnt_zero;
  logic w_misalign;
  logic w_take_redirect;
  logic w_latch;
  logic w_advance;
  logic w_dec;
  logic w_load_cnt;
  logic [WORD_W-1:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign_err;

  assign w_misalign = redirect_valid && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign_err <= 1'b0;
    end else if ((r_state != HALT) && w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign w_target = alignWord(redirect_target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT: begin
        if (w_misalign)          w_next_state = HALT;
        else if (redirect_valid) w_next_state = WAIT;
        else if (w_cnt_zero)     w_next_state = HOLD;
      end
      HOLD: begin
        if (w_misalign)                        w_next_state = HALT;
        else if (redirect_valid || fetch_ready) w_next_state = WAIT;
      end
      HALT:    w_next_state = HALT;
      default: w_next_state = WAIT;
    endcase
  end

  // Redirect outranks both the settle countdown and the consumer handshake.
  always_comb begin
    w_take_redirect = 1'b0;
    w_latch         = 1'b0;
    w_advance       = 1'b0;
    w_dec           = 1'b0;
    case (r_state)
      WAIT: begin
        if (!w_misalign) begin
          if (redirect_valid)  w_take_redirect = 1'b1;
          else if (w_cnt_zero) w_latch         = 1'b1;
          else                 w_dec           = 1'b1;
        end
      end
      HOLD: begin
        if (!w_misalign) begin
          if (redirect_valid)   w_take_redirect = 1'b1;
          else if (fetch_ready) w_advance       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_load_cnt = w_take_redirect | w_advance;

  fetch_wait_timer #(
    .RESET_VAL (WAIT_INIT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load_cnt),
    .i_load_val (WAIT_INIT),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_take_redirect) begin
      r_pc <= w_target;
    end else if (w_advance) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_pc_plus4 <= '0;
    end else if (w_latch) begin
      r_ir       <= imem_instr;
      r_ir_pc    <= r_pc;
      r_pc_plus4 <= r_pc + PC_STEP;
    end
  end

  assign imem_addr   = r_pc;
  assign fetch_valid = (r_state == HOLD);
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign pc_plus4    = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level reference model
// compared every cycle, plus directed checks with hand-computed values.
module tb_instr_fetch_unit;

  localparam int          MEM_WAIT = 1;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  // Second instance starting near the top of the address space.
  logic        wReset = 1'b0;
  logic        wReady = 1'b1;
  logic        wRedirValid = 1'b0;
  logic [31:0] wRedirTarget = 32'h0;
  logic [31:0] wAddr;
  logic [31:0] wInstr;
  logic        wValid;
  logic [31:0] wIr;
  logic [31:0] wIrPc;
  logic [31:0] wPcPlus4;
  logic        wErr;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: word 0 is a fixed opcode, others encode their address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign imem_instr = memWord(imem_addr);
  assign wInstr     = memWord(wAddr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WAIT(MEM_WAIT)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC), .MEM_WAIT(MEM_WAIT)) u_wrap (
    .clk             (clk),
    .reset           (wReset),
    .imem_addr       (wAddr),
    .imem_instr      (wInstr),
    .fetch_valid     (wValid),
    .fetch_ready     (wReady),
    .redirect_valid  (wRedirValid),
    .redirect_target (wRedirTarget),
    .ir              (wIr),
    .ir_pc           (wIrPc),
    .pc_plus4        (wPcPlus4),
    .misalign_err    (wErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] target);
    @(negedge clk);
    fetch_ready     = ready;
    redirect_valid  = redir;
    redirect_target = target;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!fetch_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Reference model: an address becomes a valid word MEM_WAIT+1 edges after it was set.
  logic [31:0] mPc = 32'h0;
  logic [31:0] mIr = 32'h0;
  logic [31:0] mIrPc = 32'h0;
  logic        mValid = 1'b0;
  logic        mErr = 1'b0;
  logic        mHalt = 1'b0;
  int          mAge = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPc = 32'h0; mValid = 1'b0; mAge = 0; mErr = 1'b0; mHalt = 1'b0;
      mIr = 32'h0; mIrPc = 32'h0;
    end else if (!mHalt) begin
      if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_target % 4 != 0) begin
          mHalt = 1'b1; mErr = 1'b1; mValid = 1'b0;
        end else begin
          mPc = redirect_target; mValid = 1'b0; mAge = 0;
        end
`else
        mPc = redirect_target - (redirect_target % 4);
        mValid = 1'b0; mAge = 0;
`endif
      end else if (mValid) begin
        if (fetch_ready) begin
          mPc = mPc + 4; mValid = 1'b0; mAge = 0;
        end
      end else begin
        mAge++;
        if (mAge == MEM_WAIT + 1) begin
          mValid = 1'b1; mIr = memWord(mPc); mIrPc = mPc;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, mValid});
    checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, mErr});
    if (mValid) begin
      checkOutput("ir", ir, mIr);
      checkOutput("ir_pc", ir_pc, mIrPc);
      checkOutput("pc_plus4", pc_plus4, mIrPc + 32'd4);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    logic [31:0] gotPc [4];
    int          gotCyc [4];

    #1;
    reset  = 1'b1;
    wReset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset imem_addr", imem_addr, 32'h0);
    checkOutput("reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("reset ir", ir, 32'h0);
    reset = 1'b0;

    // First fetch after reset release.
    waitValid(n);
    checkOutput("first valid edges", n, 2);
    checkOutput("first ir", ir, 32'h2001_0005);
    checkOutput("first ir_pc", ir_pc, 32'h0);
    checkOutput("first pc_plus4", pc_plus4, 32'h4);

    // Consumer stalls for 5 cycles.
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall fetch_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("stall ir", ir, 32'h2001_0005);
    checkOutput("stall imem_addr", imem_addr, 32'h0);

    // Streaming with ready held high.
    applyStimulus(1'b1, 1'b0, 32'h0);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 30) begin
      if (fetch_valid) begin
        gotPc[n] = ir_pc; gotCyc[n] = cyc; n++;
        if (n == 4) fetch_ready = 1'b0;
      end
      if (n < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("stream count", n, 4);
    for (int i = 0; i < n; i++) begin
      checkOutput("stream ir_pc", gotPc[i], 32'(4 * i));
      checkOutput("stream spacing", gotCyc[i], 3 * i);
    end

    // Accept word 12, then redirect while the fetch of 16 is in flight.
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0040);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redirect no latch", {31'b0, fetch_valid}, 32'h0);
    waitValid(n);
    checkOutput("redirect latency", n, 2);
    checkOutput("redirect ir", ir, 32'hA5A5_0040);
    checkOutput("redirect ir_pc", ir_pc, 32'h0000_0040);

    // Misaligned redirect coinciding with a handshake.
    applyStimulus(1'b1, 1'b1, 32'h0000_0042);
    applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("halt misalign_err", {31'b0, misalign_err}, 32'h1);
    checkOutput("halt fetch_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("halt imem_addr", imem_addr, 32'h0000_0040);
`else
    waitValid(n);
    checkOutput("masked latency", n, 2);
    checkOutput("masked ir_pc", ir_pc, 32'h0000_0040);
    checkOutput("masked misalign_err", {31'b0, misalign_err}, 32'h0);
`endif

    // Wrap-around instance.
    checkOutput("wrap reset addr", wAddr, WRAP_PC);
    @(negedge clk);
    wReset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("wrap first valid", {31'b0, wValid}, 32'h1);
    checkOutput("wrap first ir_pc", wIrPc, 32'hFFFF_FFFC);
    checkOutput("wrap first pc_plus4", wPcPlus4, 32'h0);
    checkOutput("wrap first ir", wIr, 32'hA5A5_FFFC);
    repeat (3) @(negedge clk);
    wReady = 1'b0;
    checkOutput("wrap second valid", {31'b0, wValid}, 32'h1);
    checkOutput("wrap second ir_pc", wIrPc, 32'h0);
    checkOutput("wrap second pc_plus4", wPcPlus4, 32'h4);
    checkOutput("wrap second ir", wIr, 32'h2001_0005);

    // Asynchronous reset mid-HOLD, observed between clock edges.
    #2;
    wReset = 1'b1;
    #1;
    checkOutput("async reset valid", {31'b0, wValid}, 32'h0);
    checkOutput("async reset addr", wAddr, WRAP_PC);
    checkOutput("async reset ir", wIr, 32'h0);
    @(negedge clk);
    wReset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multicycle MIPS processor, directly upstream of the instruction memory. Holds the program counter, drives the instruction-memory address, waits a fixed number of cycles for the memory's buffered output to settle, and latches the word into an instruction register. The latched word is offered to decode/control through a valid/ready handshake. Accepts a redirect (branch/jump target) from later stages.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WAIT, 1, extra settle cycles after address change before sampling; legal range 0..7.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals internal PC.
- imem_instr  in  32  word returned by instruction memory.
- fetch_valid  out  1  ir/ir_pc/pc_plus4 hold a valid fetched instruction.
- fetch_ready  in  1  consumer accepts the instruction this cycle.
- redirect_valid  in  1  load redirect_target as new PC; flushes current fetch.
- redirect_target  in  32  new PC byte address.
- ir  out  32  instruction register.
- ir_pc  out  32  address the ir word was fetched from.
- pc_plus4  out  32  ir_pc + 4, registered with ir.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: WAIT, HOLD, HALT (HALT only with the macro defined).
- Reset (async): pc=RESET_PC, state=WAIT, cnt=MEM_WAIT, ir=0, ir_pc=0, pc_plus4=0, fetch_valid=0, misalign_err=0.
- WAIT: imem_addr=pc stable. If cnt!=0: cnt-=1. If cnt==0: ir<=imem_instr, ir_pc<=pc, pc_plus4<=pc+4, fetch_valid<=1, go HOLD.
- HOLD: outputs held stable. If fetch_ready: pc<=pc+4, cnt<=MEM_WAIT, fetch_valid<=0, go WAIT.
- Redirect (any state except HALT) has priority: pc<=target, cnt<=MEM_WAIT, fetch_valid<=0, go WAIT. In a HOLD cycle with ready and redirect both high, the handshake counts as completed (consumer keeps the word); the PC takes the target, not pc+4.
- Redirect in WAIT aborts the in-flight fetch; no partial word is latched.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- fetch_ready ignored when fetch_valid=0.

## Timing
- imem_addr is registered; it changes only on a clock edge, giving the memory's buffer delay a full period to settle. Clock period must exceed memory delay / (MEM_WAIT+1).
- First fetch_valid rises after MEM_WAIT+1 edges following reset deassertion.
- Redirect-to-valid latency: MEM_WAIT+1 cycles after the redirect edge.
- Sustained throughput with fetch_ready held high: one instruction per MEM_WAIT+2 cycles.
- Reset asserted mid-WAIT or mid-HOLD: all outputs return to reset values immediately, no clock required.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with target[1:0]!=0 sets misalign_err=1, fetch_valid=0, enters HALT; PC is not updated; only reset exits HALT.
- Not defined: target[1:0] is forced to 2'b00 on load, misalign_err tied 0, HALT state absent.

## Structure
- fetch_pkg: state enum (WAIT, HOLD, HALT), WORD_W=32, PC_STEP=4, default RESET_PC constant.
- One sub-module: fetch_wait_timer (3-bit loadable down-counter with zero flag; load on reset/redirect/accept).
- Top holds PC, IR, FSM.

## Test plan
- Reset release, MEM_WAIT=1, mem[0]=32'h2001_0005 -> imem_addr=0, fetch_valid rises after 2nd edge, ir=32'h2001_0005, ir_pc=0, pc_plus4=4.
- fetch_ready held high, mem[0..3] distinct -> ir_pc sequence 0,4,8,12, one valid word every 3 cycles, no word repeated or skipped.
- fetch_ready low for 5 cycles in HOLD -> ir/ir_pc/fetch_valid unchanged; imem_addr stays at ir_pc.
- Redirect to 32'h0000_0040 mid-WAIT -> no word latched from old PC; next valid ir=mem[16], ir_pc=32'h40.
- Redirect to 32'h0000_0042 in same cycle as ready: macro defined -> misalign_err=1, fetch_valid stays 0 until reset; macro undefined -> ir_pc=32'h40.
- RESET_PC=32'hFFFF_FFFC, ready high -> second ir_pc=0 (wrap); reset pulsed while in HOLD -> fetch_valid=0, imem_addr=RESET_PC asynchronously.
